// File: rtl/updi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updi_pkg
// Brief    : Shared UPDI frame types and line constants.
// Revision : 1.0 - initial release
// ============================================================================
package updi_pkg;

    localparam int FRAME_W = 12;

    typedef logic [FRAME_W-1:0] updi_frame_t;

    localparam logic       UPDI_IDLE = 1'b1;
    localparam logic       START_BIT = 1'b0;
    localparam logic [1:0] STOP_BITS = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_GAP   = 2'd2
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/updi_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : updi_tx_fifo
// Brief    : Synchronous show-ahead FIFO holding frames awaiting transmission.
// Revision : 1.0 - initial release
// ============================================================================
module updi_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full/empty come only from the registered count, so a pop in the same
    // cycle never opens room for a push into a full buffer.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/updi_phy_tx.sv
`default_nettype none
// ============================================================================
// Module   : updi_phy_tx
// Brief    : UPDI transmit PHY - frame FIFO plus LSB-first bit serializer.
// Revision : 1.0 - initial release
// ============================================================================
module updi_phy_tx
    import updi_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_BITS   = 0
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [FRAME_W-1:0]  i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output logic                o_tx,
    output logic                o_tx_oe,
    output logic                o_busy,
    output logic                o_empty,
    output logic                o_frame_done
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BW-1:0] c_BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [3:0]    c_BIT_LAST  = 4'(FRAME_W - 1);
    localparam logic [3:0]    c_GAP_LAST  = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;
    localparam bit            c_HAS_GAP   = (GAP_BITS > 0);

    tx_state_e   r_state;
    updi_frame_t r_shreg;
    logic [3:0]  r_bit_cnt;
    logic [BW-1:0] r_baud;
    logic [3:0]  r_gap_cnt;

    tx_state_e   w_state_nxt;
    updi_frame_t w_shreg_nxt;
    logic [3:0]  w_bit_cnt_nxt;
    logic [BW-1:0] w_baud_nxt;
    logic [3:0]  w_gap_cnt_nxt;

    updi_frame_t   w_fifo_dout;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic          w_have_frame;
    logic          w_pop;
    logic          w_baud_end;
    logic          w_frame_end;
    logic          w_busy;

    updi_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (i_valid),
        .i_data  (i_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_have_frame = (w_fifo_count != '0);
    assign w_baud_end   = (r_baud == c_BAUD_LAST);
    assign w_frame_end  = (r_state == TX_SHIFT) && (r_bit_cnt == c_BIT_LAST) && w_baud_end;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= TX_IDLE;
            r_shreg   <= '1;
            r_bit_cnt <= '0;
            r_baud    <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_baud    <= w_baud_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_baud_nxt    = w_baud_end ? '0 : r_baud + BW'(1);
        w_pop         = 1'b0;

        case (r_state)
            TX_IDLE: begin
                w_baud_nxt = '0;
                if (w_have_frame) begin
                    w_state_nxt   = TX_SHIFT;
                    w_shreg_nxt   = w_fifo_dout;
                    w_bit_cnt_nxt = '0;
                    w_pop         = 1'b1;
                end
            end
            TX_SHIFT: begin
                if (w_baud_end) begin
                    w_shreg_nxt   = {UPDI_IDLE, r_shreg[FRAME_W-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_bit_cnt_nxt = '0;
                        if (c_HAS_GAP) begin
                            w_state_nxt   = TX_GAP;
                            w_gap_cnt_nxt = '0;
                        end else if (w_have_frame) begin
                            w_shreg_nxt = w_fifo_dout;
                            w_pop       = 1'b1;
                        end else begin
                            w_state_nxt = TX_IDLE;
                        end
                    end
                end
            end
            TX_GAP: begin
                if (w_baud_end) begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                    if (r_gap_cnt == c_GAP_LAST) begin
                        w_gap_cnt_nxt = '0;
                        if (w_have_frame) begin
                            w_state_nxt   = TX_SHIFT;
                            w_shreg_nxt   = w_fifo_dout;
                            w_bit_cnt_nxt = '0;
                            w_pop         = 1'b1;
                        end else begin
                            w_state_nxt = TX_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
            end
        endcase
    end

    // Line level is decoded from registered state so reset forces idle-high at once.
    assign w_busy       = (r_state != TX_IDLE);
    assign o_tx         = (r_state == TX_SHIFT) ? r_shreg[0] : UPDI_IDLE;
    assign o_tx_oe      = w_busy;
    assign o_busy       = w_busy;
    assign o_empty      = w_fifo_empty;
    assign o_ready      = !w_fifo_full;
    assign o_frame_done = w_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_updi_phy_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_updi_phy_tx
// Brief    : Directed self-checking bench for the UPDI transmit PHY.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updi_phy_tx;
    import updi_pkg::*;

    localparam int DIV       = 4;
    localparam int FRAME_CYC = 12 * DIV;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_valid;
    logic [11:0] i_data;
    logic        tx, oe, busy, empty, ready, done;
    logic        g_valid;
    logic [11:0] g_data;
    logic        g_tx, g_oe, g_busy, g_empty, g_ready, g_done;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    bit   rec0 = 1'b0;
    bit   rec1 = 1'b0;
    logic line_q[$];
    logic gap_q[$];
    logic [11:0] tx_frames[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  dec_bytes[$];
    int          dec_starts[$];

    updi_phy_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .GAP_BITS(0)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_data(i_data), .i_valid(i_valid),
        .o_ready(ready), .o_tx(tx), .o_tx_oe(oe), .o_busy(busy),
        .o_empty(empty), .o_frame_done(done)
    );

    updi_phy_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .GAP_BITS(2)) dut_gap (
        .i_clk(clk), .i_rstn(rstn), .i_data(g_data), .i_valid(g_valid),
        .o_ready(g_ready), .o_tx(g_tx), .o_tx_oe(g_oe), .o_busy(g_busy),
        .o_empty(g_empty), .o_frame_done(g_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rec0) line_q.push_back(tx);
        if (rec1) gap_q.push_back(g_tx);
        if (done) done_cnt++;
    end

    function automatic logic [11:0] make_frame(input logic [7:0] b);
        return {STOP_BITS, ^b, b, START_BIT};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_all(input bit check_full);
        int   acc;
        logic rdy;
        acc = 0;
        for (int c = 0; c < 3000 && acc < tx_frames.size(); c++) begin
            i_valid = 1'b1;
            i_data  = tx_frames[acc];
            rdy     = ready;
            step();
            if (rdy) begin
                acc++;
                if (check_full && acc == 5) chk("ready_low_after_5", ready, 0);
            end
        end
        i_valid = 1'b0;
        chk("push_all_count", acc, tx_frames.size());
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (!busy && empty) break;
            step();
        end
        chk("idle_timeout", {busy, empty}, 2'b01);
    endtask

    // Line-level UART recovery: sample each bit mid-period after a start bit.
    task automatic decode_line();
        int          i;
        logic [11:0] f;
        dec_bytes.delete();
        dec_starts.delete();
        i = 0;
        while (i + FRAME_CYC <= line_q.size()) begin
            if (line_q[i] == 1'b0) begin
                for (int b = 0; b < 12; b++) f[b] = line_q[i + b*DIV + 2];
                chk("frame_format", {f[11:10], f[9] ^ (^f[8:1]), f[0]}, 4'b1100);
                dec_bytes.push_back(f[8:1]);
                dec_starts.push_back(i);
                i += FRAME_CYC;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_single(input logic [11:0] frame);
        int base;
        base    = done_cnt;
        i_valid = 1'b1;
        i_data  = frame;
        step();
        i_valid = 1'b0;
        chk("single_empty_after_push", {empty, busy, tx}, 3'b001);
        step();
        chk("single_start_oe", {busy, oe, empty}, 3'b111);
        for (int c = 0; c < FRAME_CYC; c++) begin
            chk("single_tx_bit", tx, frame[c / DIV]);
            chk("single_frame_done", done, (c == FRAME_CYC - 1));
            step();
        end
        chk("single_end_idle", {busy, oe, tx}, 3'b001);
        chk("single_done_count", done_cnt - base, 1);
    endtask

    initial begin
        int          base;
        int          s;
        int          run;
        bit          found;
        logic [7:0]  b2 [6];

        rstn    = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        g_valid = 1'b0;
        g_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx",    tx,    1);
        chk("rst_oe",    oe,    0);
        chk("rst_busy",  busy,  0);
        chk("rst_empty", empty, 1);
        chk("rst_ready", ready, 1);
        chk("rst_done",  done,  0);
        chk("rst_gap_outputs", {g_tx, g_oe, g_busy, g_empty, g_ready, g_done}, 6'b100110);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // Single frame 0xA5 -> 12'hD4A on the line, LSB first.
        check_single(12'hD4A);

        // Six back-to-back frames into a depth-4 FIFO.
        b2 = '{8'h00, 8'hFF, 8'h81, 8'h7E, 8'h3C, 8'hC3};
        tx_frames.delete();
        foreach (b2[k]) tx_frames.push_back(make_frame(b2[k]));
        line_q.delete();
        base = done_cnt;
        rec0 = 1'b1;
        push_all(1'b1);
        wait_idle(800);
        rec0 = 1'b0;
        decode_line();
        chk("b2b_frame_count", dec_bytes.size(), 6);
        for (int k = 0; k < 6 && k < dec_bytes.size(); k++) begin
            chk("b2b_byte", dec_bytes[k], b2[k]);
            if (k > 0) chk("b2b_no_gap", dec_starts[k] - dec_starts[k-1], FRAME_CYC);
        end
        chk("b2b_done_count", done_cnt - base, 6);

        // GAP_BITS=2 instance: two frames, 8 idle-high cycles between them.
        gap_q.delete();
        rec1    = 1'b1;
        g_valid = 1'b1;
        g_data  = make_frame(8'h5A);
        step();
        g_data  = make_frame(8'hA5);
        step();
        g_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!g_busy && g_empty) break;
            step();
        end
        chk("gap_idle_timeout", {g_busy, g_empty, g_oe}, 3'b010);
        rec1 = 1'b0;
        s = -1;
        for (int i = 0; i < gap_q.size(); i++) begin
            if (gap_q[i] == 1'b0) begin
                s = i;
                break;
            end
        end
        run   = 0;
        found = 1'b0;
        if (s >= 0) begin
            for (int j = s + FRAME_CYC; j < gap_q.size(); j++) begin
                if (gap_q[j] == 1'b0) begin
                    found = 1'b1;
                    break;
                end
                run++;
            end
        end
        chk("gap_second_start_seen", found, 1);
        chk("gap_high_cycles", run, 2 * DIV);

        // SYNCH then 40 random bytes, recovered from the line.
        tx_frames.delete();
        exp_bytes.delete();
        exp_bytes.push_back(8'h55);
        for (int k = 0; k < 40; k++) exp_bytes.push_back(8'($urandom_range(0, 255)));
        foreach (exp_bytes[k]) tx_frames.push_back(make_frame(exp_bytes[k]));
        line_q.delete();
        base = done_cnt;
        rec0 = 1'b1;
        push_all(1'b0);
        wait_idle(4000);
        rec0 = 1'b0;
        decode_line();
        chk("rand_frame_count", dec_bytes.size(), 41);
        for (int k = 0; k < 41 && k < dec_bytes.size(); k++) begin
            chk("rand_byte", dec_bytes[k], exp_bytes[k]);
        end
        chk("rand_done_count", done_cnt - base, 41);
        chk("rand_end_state", {empty, busy}, 2'b10);

        // Reset in the middle of bit 5 with two frames still queued.
        tx_frames.delete();
        tx_frames.push_back(make_frame(8'h11));
        tx_frames.push_back(make_frame(8'h22));
        tx_frames.push_back(make_frame(8'h33));
        push_all(1'b0);
        chk("pre_rst_queued", {busy, empty, ready}, 3'b101);
        repeat (20) step();
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_tx",    tx,    1);
        chk("midrst_oe",    oe,    0);
        chk("midrst_empty", empty, 1);
        chk("midrst_busy",  busy,  0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        chk("post_rst_flushed", {busy, empty}, 2'b01);
        check_single(make_frame(8'h3C));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
